decode_stage: RTL and testbench

- Single-cycle RV32I instruction decoder with an ID/EX pipeline register between fetch and execute.
- Accepts a fetched instruction and PC through a valid/ready handshake.
- Produces the ALU operation, operand A/B selects, writeback select, immediate and memory/branch controls from control_pkg.
- Supports backpressure from execute and a synchronous flush for taken branches and traps.

---
 rtl/decode_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage (with control_pkg)
// Purpose  : Single-cycle RV32I instruction decoder with an ID/EX pipeline
//            register. It takes an instruction and PC from fetch over a
//            valid/ready handshake and presents the decoded control word to
//            execute on the next cycle. Execute can apply backpressure, and a
//            synchronous flush kills the stage for taken branches and traps.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   if_valid_i          fetch presents an instruction
//   if_ready_o          decode can accept this cycle
//   if_instr_i/if_pc_i  instruction word and its PC
//   flush_i             kill stage contents and any same-cycle input
//   ex_ready_i          execute accepts the current output
//   ex_valid_o          output payload valid
//   ex_*_o              registered decode payload: PC, register indices,
//                       immediate, funct3, ALU op/operand selects, writeback
//                       select, register/memory/branch/jump enables, illegal
// ============================================================================

package control_pkg;

  // The ALU operation is {bit30 qualifier, funct3}. Only the codes the decoder
  // names directly are listed; others pass through as raw 4-bit values.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } e_alu_operation_sel;

  typedef enum logic [1:0] {
    ALU_RS1  = 2'd0,
    ALU_PC   = 2'd1,
    ALU_ZERO = 2'd2
  } e_alu_operand_a_sel;

  typedef enum logic [0:0] {
    ALU_RS2 = 1'b0,
    ALU_IMM = 1'b1
  } e_alu_operand_b_sel;

  typedef enum logic [1:0] {
    WB_ALU_OUT  = 2'd0,
    WB_MEM_LOAD = 2'd1,
    WB_PC_PLS4  = 2'd2
  } e_regfile_wb_sel;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

module decode_stage
  import control_pkg::*;
#(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [4:0]      ex_rs1_addr_o,
  output logic [4:0]      ex_rs2_addr_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [2:0]      ex_funct3_o,
  output logic [3:0]      ex_alu_op_o,
  output logic [1:0]      ex_alu_a_sel_o,
  output logic            ex_alu_b_sel_o,
  output logic [1:0]      ex_wb_sel_o,
  output logic            ex_rf_we_o,
  output logic            ex_mem_re_o,
  output logic            ex_mem_we_o,
  output logic            ex_branch_o,
  output logic            ex_jump_o,
  output logic            ex_illegal_o
);

  // --------------------------------------------------------------------------
  // Instruction fields and immediates
  // --------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign opcode = if_instr_i[6:0];
  assign funct3 = if_instr_i[14:12];
  assign funct7 = if_instr_i[31:25];
  assign rd     = if_instr_i[11:7];

  assign imm_i = {{(XLEN-12){if_instr_i[31]}}, if_instr_i[31:20]};
  assign imm_s = {{(XLEN-12){if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
  assign imm_b = {{(XLEN-13){if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                  if_instr_i[30:25], if_instr_i[11:8], 1'b0};
  assign imm_u = {if_instr_i[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                  if_instr_i[20], if_instr_i[30:21], 1'b0};

  // --------------------------------------------------------------------------
  // Combinational decode (next payload)
  // --------------------------------------------------------------------------
  logic [3:0]         alu_op_d;
  e_alu_operand_a_sel a_sel_d;
  e_alu_operand_b_sel b_sel_d;
  e_regfile_wb_sel    wb_sel_d;
  logic [XLEN-1:0]    imm_d;
  logic               illegal_d;
  logic               rf_we_raw;
  logic               mem_re_raw;
  logic               mem_we_raw;
  logic               branch_raw;
  logic               jump_raw;
  logic               rf_we_d;
  logic               mem_re_d;
  logic               mem_we_d;
  logic               branch_d;
  logic               jump_d;

  always_comb begin
    alu_op_d   = ALU_ADD;
    a_sel_d    = ALU_RS1;
    b_sel_d    = ALU_RS2;
    wb_sel_d   = WB_ALU_OUT;
    imm_d      = '0;
    illegal_d  = 1'b0;
    rf_we_raw  = 1'b0;
    mem_re_raw = 1'b0;
    mem_we_raw = 1'b0;
    branch_raw = 1'b0;
    jump_raw   = 1'b0;

    // Matching the full 7-bit opcode also rejects instr[1:0] != 2'b11.
    case (opcode)
      OPC_OP: begin
        alu_op_d  = {if_instr_i[30], funct3};
        rf_we_raw = 1'b1;
        // funct7 0100000 is only meaningful for SUB and SRA.
        if (!((funct7 == 7'b0000000) ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
          illegal_d = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only SRAI uses bit 30 as an op qualifier; elsewhere it is immediate.
        alu_op_d  = {(funct3 == 3'b101) && if_instr_i[30], funct3};
        b_sel_d   = ALU_IMM;
        imm_d     = imm_i;
        rf_we_raw = 1'b1;
        if (funct3 == 3'b001 && funct7 != 7'b0000000)
          illegal_d = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
          illegal_d = 1'b1;
      end
      OPC_LUI: begin
        a_sel_d   = ALU_ZERO;
        b_sel_d   = ALU_IMM;
        imm_d     = imm_u;
        rf_we_raw = 1'b1;
      end
      OPC_AUIPC: begin
        a_sel_d   = ALU_PC;
        b_sel_d   = ALU_IMM;
        imm_d     = imm_u;
        rf_we_raw = 1'b1;
      end
      OPC_JAL: begin
        a_sel_d   = ALU_PC;
        b_sel_d   = ALU_IMM;
        imm_d     = imm_j;
        wb_sel_d  = WB_PC_PLS4;
        jump_raw  = 1'b1;
        rf_we_raw = 1'b1;
      end
      OPC_JALR: begin
        b_sel_d   = ALU_IMM;
        imm_d     = imm_i;
        wb_sel_d  = WB_PC_PLS4;
        jump_raw  = 1'b1;
        rf_we_raw = 1'b1;
        if (funct3 != 3'b000)
          illegal_d = 1'b1;
      end
      OPC_BRANCH: begin
        imm_d      = imm_b;
        branch_raw = 1'b1;
        // The ALU result drives the compare; funct3 picks the sense.
        case (funct3)
          3'b000, 3'b001: alu_op_d  = ALU_SUB;
          3'b100, 3'b101: alu_op_d  = ALU_SLT;
          3'b110, 3'b111: alu_op_d  = ALU_SLTU;
          default:        illegal_d = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        b_sel_d    = ALU_IMM;
        imm_d      = imm_i;
        wb_sel_d   = WB_MEM_LOAD;
        mem_re_raw = 1'b1;
        rf_we_raw  = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_d = 1'b0;
          default:                                illegal_d = 1'b1;
        endcase
      end
      OPC_STORE: begin
        b_sel_d    = ALU_IMM;
        imm_d      = imm_s;
        mem_we_raw = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b010: illegal_d = 1'b0;
          default:                illegal_d = 1'b1;
        endcase
      end
      OPC_MISC_MEM: begin
        // FENCE: no ordering hazards exist in this pipeline, so it is a NOP.
        b_sel_d = ALU_IMM;
        imm_d   = imm_i;
      end
      OPC_SYSTEM: begin
        // ECALL/EBREAK have no datapath action; flagging them lets execute trap.
        imm_d     = imm_i;
        illegal_d = 1'b1;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase

    rf_we_d  = rf_we_raw  && !illegal_d && (rd != 5'd0);
    mem_re_d = mem_re_raw && !illegal_d;
    mem_we_d = mem_we_raw && !illegal_d;
    branch_d = branch_raw && !illegal_d;
    jump_d   = jump_raw   && !illegal_d;
  end

  // --------------------------------------------------------------------------
  // Handshake and ID/EX register
  // --------------------------------------------------------------------------
  logic               valid_q;
  logic               valid_d;
  logic               if_accept;
  logic [XLEN-1:0]    pc_q;
  logic [4:0]         rs1_q;
  logic [4:0]         rs2_q;
  logic [4:0]         rd_q;
  logic [XLEN-1:0]    imm_q;
  logic [2:0]         funct3_q;
  logic [3:0]         alu_op_q;
  e_alu_operand_a_sel a_sel_q;
  e_alu_operand_b_sel b_sel_q;
  e_regfile_wb_sel    wb_sel_q;
  logic               rf_we_q;
  logic               mem_re_q;
  logic               mem_we_q;
  logic               branch_q;
  logic               jump_q;
  logic               illegal_q;

  assign if_ready_o = !valid_q || ex_ready_i;
  assign if_accept  = if_valid_i && if_ready_o;

  // Flush wins over a same-cycle accept; the payload may still load but is
  // never presented because valid stays low.
  always_comb begin
    valid_d = valid_q;
    if (flush_i)
      valid_d = 1'b0;
    else if (if_accept)
      valid_d = 1'b1;
    else if (ex_ready_i)
      valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      funct3_q  <= '0;
      alu_op_q  <= ALU_ADD;
      a_sel_q   <= ALU_RS1;
      b_sel_q   <= ALU_RS2;
      wb_sel_q  <= WB_ALU_OUT;
      rf_we_q   <= 1'b0;
      mem_re_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      branch_q  <= 1'b0;
      jump_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      // if_ready_o is low while stalled, so the payload cannot change then.
      if (if_accept) begin
        pc_q      <= if_pc_i;
        rs1_q     <= if_instr_i[19:15];
        rs2_q     <= if_instr_i[24:20];
        rd_q      <= rd;
        imm_q     <= imm_d;
        funct3_q  <= funct3;
        alu_op_q  <= alu_op_d;
        a_sel_q   <= a_sel_d;
        b_sel_q   <= b_sel_d;
        wb_sel_q  <= wb_sel_d;
        rf_we_q   <= rf_we_d;
        mem_re_q  <= mem_re_d;
        mem_we_q  <= mem_we_d;
        branch_q  <= branch_d;
        jump_q    <= jump_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign ex_valid_o     = valid_q;
  assign ex_pc_o        = pc_q;
  assign ex_rs1_addr_o  = rs1_q;
  assign ex_rs2_addr_o  = rs2_q;
  assign ex_rd_addr_o   = rd_q;
  assign ex_imm_o       = imm_q;
  assign ex_funct3_o    = funct3_q;
  assign ex_alu_op_o    = alu_op_q;
  assign ex_alu_a_sel_o = a_sel_q;
  assign ex_alu_b_sel_o = b_sel_q;
  assign ex_wb_sel_o    = wb_sel_q;
  assign ex_rf_we_o     = rf_we_q;
  assign ex_mem_re_o    = mem_re_q;
  assign ex_mem_we_o    = mem_we_q;
  assign ex_branch_o    = branch_q;
  assign ex_jump_o      = jump_q;
  assign ex_illegal_o   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Self-checking bench for decode_stage. A behavioural reference
//            model tracks the expected stage contents; a compare process
//            checks every output on each falling edge. Directed literal
//            checks pin the decode of specific instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
  import control_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc_i;
  logic        flush_i;
  logic        ex_ready_i;
  logic        ex_valid_o;
  logic [31:0] ex_pc_o;
  logic [4:0]  ex_rs1_addr_o;
  logic [4:0]  ex_rs2_addr_o;
  logic [4:0]  ex_rd_addr_o;
  logic [31:0] ex_imm_o;
  logic [2:0]  ex_funct3_o;
  logic [3:0]  ex_alu_op_o;
  logic [1:0]  ex_alu_a_sel_o;
  logic        ex_alu_b_sel_o;
  logic [1:0]  ex_wb_sel_o;
  logic        ex_rf_we_o;
  logic        ex_mem_re_o;
  logic        ex_mem_we_o;
  logic        ex_branch_o;
  logic        ex_jump_o;
  logic        ex_illegal_o;

  decode_stage #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid_i     (if_valid_i),
    .if_ready_o     (if_ready_o),
    .if_instr_i     (if_instr_i),
    .if_pc_i        (if_pc_i),
    .flush_i        (flush_i),
    .ex_ready_i     (ex_ready_i),
    .ex_valid_o     (ex_valid_o),
    .ex_pc_o        (ex_pc_o),
    .ex_rs1_addr_o  (ex_rs1_addr_o),
    .ex_rs2_addr_o  (ex_rs2_addr_o),
    .ex_rd_addr_o   (ex_rd_addr_o),
    .ex_imm_o       (ex_imm_o),
    .ex_funct3_o    (ex_funct3_o),
    .ex_alu_op_o    (ex_alu_op_o),
    .ex_alu_a_sel_o (ex_alu_a_sel_o),
    .ex_alu_b_sel_o (ex_alu_b_sel_o),
    .ex_wb_sel_o    (ex_wb_sel_o),
    .ex_rf_we_o     (ex_rf_we_o),
    .ex_mem_re_o    (ex_mem_re_o),
    .ex_mem_we_o    (ex_mem_we_o),
    .ex_branch_o    (ex_branch_o),
    .ex_jump_o      (ex_jump_o),
    .ex_illegal_o   (ex_illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [1:0]  a;
    logic        b;
    logic [1:0]  wb;
    logic        rf_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic        care_alu;  // ALU op / selects / wb are defined for this instr
    logic        care_imm;  // immediate is defined for this instr
  } exp_t;

  // Sign-extend the low w bits of v using plain arithmetic.
  function automatic logic [31:0] sext(input logic [31:0] v, input int w);
    longint x;
    x = longint'(v);
    if (v[w-1]) x = x - (longint'(1) << w);
    return x[31:0];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    e = '0;
    e.pc  = pc;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.f3  = f3;
    e.care_alu = 1'b1;
    e.care_imm = 1'b1;
    e.alu = ALU_ADD;
    e.a   = ALU_RS1;
    e.b   = ALU_RS2;
    e.wb  = WB_ALU_OUT;
    case (ins[6:0])
      7'b0110011: begin
        e.alu = {ins[30], f3};
        e.rf_we = 1'b1;
        e.care_imm = 1'b0;
        e.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'b0010011: begin
        e.alu = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
        e.b = ALU_IMM;
        e.imm = sext(32'(ins[31:20]), 12);
        e.rf_we = 1'b1;
        if (f3 == 3'd1) e.illegal = (f7 != 7'h00);
        if (f3 == 3'd5) e.illegal = !(f7 == 7'h00 || f7 == 7'h20);
      end
      7'b0110111: begin
        e.a = ALU_ZERO; e.b = ALU_IMM; e.imm = {ins[31:12], 12'h000}; e.rf_we = 1'b1;
      end
      7'b0010111: begin
        e.a = ALU_PC; e.b = ALU_IMM; e.imm = {ins[31:12], 12'h000}; e.rf_we = 1'b1;
      end
      7'b1101111: begin
        e.a = ALU_PC; e.b = ALU_IMM; e.wb = WB_PC_PLS4; e.jump = 1'b1; e.rf_we = 1'b1;
        e.imm = sext(32'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      end
      7'b1100111: begin
        e.b = ALU_IMM; e.wb = WB_PC_PLS4; e.jump = 1'b1; e.rf_we = 1'b1;
        e.imm = sext(32'(ins[31:20]), 12);
        e.illegal = (f3 != 3'd0);
      end
      7'b1100011: begin
        e.branch = 1'b1;
        e.imm = sext(32'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
        if (f3 == 3'd0 || f3 == 3'd1)      e.alu = ALU_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) e.alu = ALU_SLT;
        else if (f3 == 3'd6 || f3 == 3'd7) e.alu = ALU_SLTU;
        else                               e.illegal = 1'b1;
      end
      7'b0000011: begin
        e.b = ALU_IMM; e.wb = WB_MEM_LOAD; e.mem_re = 1'b1; e.rf_we = 1'b1;
        e.imm = sext(32'(ins[31:20]), 12);
        e.illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      7'b0100011: begin
        e.b = ALU_IMM; e.mem_we = 1'b1;
        e.imm = sext(32'({ins[31:25], ins[11:7]}), 12);
        e.illegal = !(f3 inside {3'd0, 3'd1, 3'd2});
      end
      7'b0001111: begin
        e.care_alu = 1'b0; e.care_imm = 1'b0;
      end
      7'b1110011: e.illegal = 1'b1;
      default:    e.illegal = 1'b1;
    endcase
    if (e.illegal) begin
      e.rf_we = 1'b0; e.mem_re = 1'b0; e.mem_we = 1'b0; e.branch = 1'b0; e.jump = 1'b0;
      e.care_alu = 1'b0; e.care_imm = 1'b0;
    end
    if (e.rd == 5'd0) e.rf_we = 1'b0;
    return e;
  endfunction

  logic m_valid = 1'b0;
  exp_t m_exp   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
    end else if (flush_i) begin
      m_valid <= 1'b0;
    end else if (if_valid_i && (!m_valid || ex_ready_i)) begin
      m_valid <= 1'b1;
      m_exp   <= ref_decode(if_instr_i, if_pc_i);
    end else if (ex_ready_i) begin
      m_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Compare process
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("if_ready_o", 32'(if_ready_o), 32'(!m_valid || ex_ready_i));
      chk("ex_valid_o", 32'(ex_valid_o), 32'(m_valid));
      if (m_valid) begin
        chk("ex_pc_o",       ex_pc_o,              m_exp.pc);
        chk("ex_rs1_addr_o", 32'(ex_rs1_addr_o),   32'(m_exp.rs1));
        chk("ex_rs2_addr_o", 32'(ex_rs2_addr_o),   32'(m_exp.rs2));
        chk("ex_rd_addr_o",  32'(ex_rd_addr_o),    32'(m_exp.rd));
        chk("ex_funct3_o",   32'(ex_funct3_o),     32'(m_exp.f3));
        chk("ex_illegal_o",  32'(ex_illegal_o),    32'(m_exp.illegal));
        chk("ex_rf_we_o",    32'(ex_rf_we_o),      32'(m_exp.rf_we));
        chk("ex_mem_re_o",   32'(ex_mem_re_o),     32'(m_exp.mem_re));
        chk("ex_mem_we_o",   32'(ex_mem_we_o),     32'(m_exp.mem_we));
        chk("ex_branch_o",   32'(ex_branch_o),     32'(m_exp.branch));
        chk("ex_jump_o",     32'(ex_jump_o),       32'(m_exp.jump));
        if (m_exp.care_alu) begin
          chk("ex_alu_op_o",    32'(ex_alu_op_o),    32'(m_exp.alu));
          chk("ex_alu_a_sel_o", 32'(ex_alu_a_sel_o), 32'(m_exp.a));
          chk("ex_alu_b_sel_o", 32'(ex_alu_b_sel_o), 32'(m_exp.b));
          chk("ex_wb_sel_o",    32'(ex_wb_sel_o),    32'(m_exp.wb));
        end
        if (m_exp.care_imm)
          chk("ex_imm_o", ex_imm_o, m_exp.imm);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    if_valid_i = 1'b1;
    if_instr_i = ins;
    if_pc_i    = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] w;
    int          k;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0001111, 7'b1110011};
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;  // fully random word
    k = $urandom_range(0, 10);
    w[6:0] = ops[k];
    // Bias funct7 toward legal encodings so legal OP / shift forms show up.
    if ($urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    return w;
  endfunction

  task automatic random_phase(input int cycles);
    logic [31:0] pcr;
    for (int i = 0; i < cycles; i++) begin
      pcr = $urandom;
      if_valid_i = ($urandom_range(0, 3) != 0);
      if_instr_i = rand_instr();
      if_pc_i    = {pcr[31:2], 2'b00};
      flush_i    = ($urandom_range(0, 15) == 0);
      ex_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    flush_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_valid_i = 1'b0; if_instr_i = '0; if_pc_i = '0;
    flush_i = 1'b0; ex_ready_i = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst ex_valid_o",   32'(ex_valid_o),     0);
    chk("rst ex_pc_o",      ex_pc_o,             0);
    chk("rst ex_imm_o",     ex_imm_o,            0);
    chk("rst ex_alu_op_o",  32'(ex_alu_op_o),    0);
    chk("rst ex_alu_a_sel", 32'(ex_alu_a_sel_o), 0);
    chk("rst ex_wb_sel_o",  32'(ex_wb_sel_o),    0);
    chk("rst ex_rf_we_o",   32'(ex_rf_we_o),     0);
    chk("rst ex_illegal_o", 32'(ex_illegal_o),   0);
    chk("rst if_ready_o",   32'(if_ready_o),     1);
    rst_n = 1'b1;

    // ADDI x1,x2,-1
    send(32'hFFF10093, 32'h0000_0000); tick();
    chk("addi valid",  32'(ex_valid_o),     1);
    chk("addi alu_op", 32'(ex_alu_op_o),    32'h0);
    chk("addi a_sel",  32'(ex_alu_a_sel_o), 0);
    chk("addi b_sel",  32'(ex_alu_b_sel_o), 1);
    chk("addi imm",    ex_imm_o,            32'hFFFF_FFFF);
    chk("addi rs1",    32'(ex_rs1_addr_o),  2);
    chk("addi rd",     32'(ex_rd_addr_o),   1);
    chk("addi rf_we",  32'(ex_rf_we_o),     1);

    // SRA x3,x4,x5
    send(32'h405251B3, 32'h0000_0004); tick();
    chk("sra alu_op", 32'(ex_alu_op_o),    32'hD);
    chk("sra b_sel",  32'(ex_alu_b_sel_o), 0);
    chk("sra wb_sel", 32'(ex_wb_sel_o),    0);
    chk("sra rd",     32'(ex_rd_addr_o),   3);

    // SLLI with instr[30]=1 is illegal
    send(32'h40111093, 32'h0000_0008); tick();
    chk("slli30 illegal", 32'(ex_illegal_o), 1);
    chk("slli30 rf_we",   32'(ex_rf_we_o),   0);

    // JAL x1,+8 at 0x100
    send(32'h008000EF, 32'h0000_0100); tick();
    chk("jal pc",    ex_pc_o,             32'h100);
    chk("jal imm",   ex_imm_o,            32'h8);
    chk("jal a_sel", 32'(ex_alu_a_sel_o), 1);
    chk("jal b_sel", 32'(ex_alu_b_sel_o), 1);
    chk("jal wb",    32'(ex_wb_sel_o),    2);
    chk("jal jump",  32'(ex_jump_o),      1);

    // Backpressure: ADD x5,x6,x7 waits behind JAL
    ex_ready_i = 1'b0;
    send(32'h007302B3, 32'h0000_0104);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall if_ready", 32'(if_ready_o), 0);
      chk("stall pc",       ex_pc_o,         32'h100);
      chk("stall jump",     32'(ex_jump_o),  1);
    end
    ex_ready_i = 1'b1;
    tick();
    chk("unstall valid", 32'(ex_valid_o),   1);
    chk("unstall pc",    ex_pc_o,           32'h104);
    chk("unstall rd",    32'(ex_rd_addr_o), 5);
    if_valid_i = 1'b0;
    tick();
    chk("no dup valid", 32'(ex_valid_o), 0);

    // Flush while stalled
    ex_ready_i = 1'b0;
    send(32'h00500393, 32'h0000_0200); tick();
    chk("pre-flush valid", 32'(ex_valid_o), 1);
    chk("pre-flush imm",   ex_imm_o,        32'h5);
    if_valid_i = 1'b0; flush_i = 1'b1;
    #1 chk("flush if_ready", 32'(if_ready_o), 0);
    tick(); flush_i = 1'b0;
    chk("flush stalled valid", 32'(ex_valid_o), 0);

    // Flush while accepting
    ex_ready_i = 1'b1;
    send(32'h00500393, 32'h0000_0300); flush_i = 1'b1;
    #1 chk("flush accept if_ready", 32'(if_ready_o), 1);
    tick(); flush_i = 1'b0; if_valid_i = 1'b0;
    chk("flush accept valid", 32'(ex_valid_o), 0);
    tick();
    chk("flushed never shows", 32'(ex_valid_o), 0);

    // All-zero word is illegal
    send(32'h0000_0000, 32'h0000_0400); tick();
    chk("zero valid",   32'(ex_valid_o),   1);
    chk("zero illegal", 32'(ex_illegal_o), 1);
    chk("zero rf_we",   32'(ex_rf_we_o),   0);
    chk("zero mem_re",  32'(ex_mem_re_o),  0);
    chk("zero mem_we",  32'(ex_mem_we_o),  0);
    chk("zero branch",  32'(ex_branch_o),  0);
    chk("zero jump",    32'(ex_jump_o),    0);
    if_valid_i = 1'b0;

    random_phase(3000);

    // Asynchronous reset mid-stream
    ex_ready_i = 1'b0;
    send(32'h00500393, 32'h0000_0500); tick();
    chk("pre-rst valid", 32'(ex_valid_o), 1);
    #2 rst_n = 1'b0;
    #1 chk("async rst valid", 32'(ex_valid_o), 0);
    chk("async rst pc", ex_pc_o, 0);
    if_valid_i = 1'b0; ex_ready_i = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    random_phase(300);
    if_valid_i = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
